// File: rtl/hp0_dma_pkg.sv
// Shared types and AXI3 constants for the HP0 write DMA.
package hp0_dma_pkg;

    localparam int unsigned BURST_BEATS = 16;
    localparam int unsigned BURST_BYTES = BURST_BEATS * 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } dma_state_e;

endpackage

// File: rtl/hp0_dma_fifo.sv
// First-word-fall-through sample FIFO with occupancy count and flush.
module hp0_dma_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full, push_ok, pop_ok;
    logic [AW-1:0]    wr_idx;

    assign full    = (count_q == CW'(DEPTH));
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop_i);
    assign pop_ok  = pop_i && (count_q != '0);
    assign wr_idx  = flush_i ? '0 : wr_ptr_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push_i ? AW'(1) : '0;
            count_q  <= push_i ? CW'(1) : '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && (flush_i || push_ok)) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full;

endmodule

// File: rtl/hp0_wr_dma.sv
// Streams 32-bit samples into a DDR ring buffer as 16-beat AXI3 bursts on HP0.
// Define HP0_WR_DMA_STATS_EN to add the burst_cnt / err_cnt statistics ports.
module hp0_wr_dma
    import hp0_dma_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [5:0]  AXI_ID     = 6'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_en,
    input  logic [31:0] cfg_base,
    input  logic [19:0] cfg_bursts,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] wr_ptr,
    output logic        err,
    output logic        ovf,
`ifdef HP0_WR_DMA_STATS_EN
    output logic [31:0] burst_cnt,
    output logic [15:0] err_cnt,
`endif
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awlen,
    output logic [5:0]  m_awid,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [1:0]  m_awburst,
    output logic [2:0]  m_awsize,
    output logic [3:0]  m_awcache,
    output logic [1:0]  m_awlock,
    output logic [2:0]  m_awprot,
    output logic [3:0]  m_awqos,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic [5:0]  m_wid,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [5:0]  m_bid,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    dma_state_e  state_q;
    logic        en_q, awvalid_q, wvalid_q, wlast_q, bready_q, err_q, ovf_q;
    logic [3:0]  beat_q;
    logic [31:0] awaddr_q, wr_ptr_q, wr_ptr_d, ring_bytes, ptr_inc;
    logic [19:0] n_bursts;
    logic [CW-1:0] fifo_count;
    logic        fifo_full, rise, clear, push, pop, bfire;
    logic        unused_inputs;

    // Registered enable edge restarts the ring, but only between bursts.
    assign rise  = cfg_en && !en_q;
    assign clear = rise && (state_q == ST_IDLE);

    assign s_ready = cfg_en && !fifo_full && !rst;
    assign push    = s_valid && s_ready;
    assign pop     = wvalid_q && m_wready;
    assign bfire   = bready_q && m_bvalid;

    hp0_dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clear),
        .push_i  (push),
        .data_i  (s_data),
        .pop_i   (pop),
        .data_o  (m_wdata),
        .count_o (fifo_count),
        .full_o  (fifo_full)
    );

    always_comb begin
        n_bursts   = (cfg_bursts == '0) ? 20'd1 : cfg_bursts;
        ring_bytes = {6'd0, n_bursts, 6'd0};
        ptr_inc    = wr_ptr_q + 32'(BURST_BYTES);
        wr_ptr_d   = (ptr_inc == ring_bytes) ? '0 : ptr_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            beat_q    <= '0;
            wr_ptr_q  <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            en_q <= cfg_en;
            if (clear) begin
                wr_ptr_q <= '0;
                err_q    <= 1'b0;
                ovf_q    <= 1'b0;
            end else if (s_valid && cfg_en && fifo_full) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cfg_en && !rise && (fifo_count >= CW'(BURST_BEATS))) begin
                        state_q   <= ST_ADDR;
                        awvalid_q <= 1'b1;
                        awaddr_q  <= {cfg_base[31:6], 6'd0} + wr_ptr_q;
                    end
                end
                ST_ADDR: begin
                    if (m_awready) begin
                        state_q   <= ST_DATA;
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= 1'b0;
                        beat_q    <= '0;
                    end
                end
                ST_DATA: begin
                    if (m_wready) begin
                        beat_q  <= beat_q + 4'd1;
                        wlast_q <= (beat_q == 4'(BURST_BEATS - 2));
                        if (wlast_q) begin
                            state_q  <= ST_RESP;
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    // Ring pointer advances even on an error response.
                    if (m_bvalid) begin
                        state_q  <= ST_IDLE;
                        bready_q <= 1'b0;
                        wr_ptr_q <= wr_ptr_d;
                        if (m_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef HP0_WR_DMA_STATS_EN
    logic [31:0] burst_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (clear) begin
            burst_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (bfire) begin
            burst_cnt_q <= burst_cnt_q + 32'd1;
            if ((m_bresp != AXI_RESP_OKAY) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign burst_cnt = burst_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

    assign unused_inputs = ^{m_bid, cfg_base[5:0], bfire};

    assign wr_ptr    = wr_ptr_q;
    assign err       = err_q;
    assign ovf       = ovf_q;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = 4'(BURST_BEATS - 1);
    assign m_awid    = AXI_ID;
    assign m_awvalid = awvalid_q;
    assign m_awburst = AXI_BURST_INCR;
    assign m_awsize  = AXI_SIZE_4B;
    assign m_awcache = AXI_CACHE_BUF;
    assign m_awlock  = 2'b00;
    assign m_awprot  = 3'b000;
    assign m_awqos   = 4'b0000;
    assign m_wstrb   = 4'hF;
    assign m_wid     = AXI_ID;
    assign m_wlast   = wlast_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;

endmodule

// File: tb/tb_hp0_wr_dma.sv
// Randomized self-checking bench for hp0_wr_dma against a queue-based ring model.
module tb_hp0_wr_dma;

    localparam int DEPTH = 64;

    logic        clk, rst, cfg_en, s_valid, s_ready, err, ovf;
    logic [31:0] cfg_base, s_data, wr_ptr;
    logic [19:0] cfg_bursts;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_awlen, m_awcache, m_awqos, m_wstrb;
    logic [5:0]  m_awid, m_wid, m_bid;
    logic [1:0]  m_awburst, m_awlock, m_bresp;
    logic [2:0]  m_awsize, m_awprot;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
`ifdef HP0_WR_DMA_STATS_EN
    logic [31:0] burst_cnt;
    logic [15:0] err_cnt;
`endif

    hp0_wr_dma #(.FIFO_DEPTH(DEPTH), .AXI_ID(6'd0)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_bursts(cfg_bursts),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wr_ptr(wr_ptr), .err(err), .ovf(ovf),
`ifdef HP0_WR_DMA_STATS_EN
        .burst_cnt(burst_cnt), .err_cnt(err_cnt),
`endif
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_awburst(m_awburst), .m_awsize(m_awsize),
        .m_awcache(m_awcache), .m_awlock(m_awlock), .m_awprot(m_awprot), .m_awqos(m_awqos),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wid(m_wid), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: sample queue, ring offset, sticky flags, burst phase.
    logic [31:0] mdl_q[$];
    logic [31:0] aw_log[$];
    logic [31:0] mdl_ptr;
    logic        mdl_err, mdl_ovf, data_ph, resp_ph, en_prev, exp_rdy;
    int          beat_idx, n_aw, n_b, mdl_bcnt, mdl_ecnt;

    // Slave knobs
    logic aw_hold, slave_rand, rand_err;
    int   stall_left, stall_beat, err_at;

    function automatic logic [31:0] ring_bytes();
        logic [31:0] nb;
        nb = (cfg_bursts == 20'd0) ? 32'd1 : 32'(cfg_bursts);
        return nb * 32'd64;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mdl_q.delete();
            mdl_ptr = 0; mdl_err = 0; mdl_ovf = 0; data_ph = 0; resp_ph = 0;
            en_prev = 0; beat_idx = 0; mdl_bcnt = 0; mdl_ecnt = 0;
        end else begin
            exp_rdy = cfg_en && (mdl_q.size() < DEPTH);
            chk("s_ready", 32'(s_ready), 32'(exp_rdy));
            chk("wr_ptr", wr_ptr, mdl_ptr);
            chk("err", 32'(err), 32'(mdl_err));
            chk("ovf", 32'(ovf), 32'(mdl_ovf));
            chk("wvalid", 32'(m_wvalid), 32'(data_ph));
            chk("bready", 32'(m_bready), 32'(resp_ph));
            chk("wlast", 32'(m_wlast), 32'(m_wvalid && beat_idx == 15));
            chk("aw_excl", 32'(m_awvalid && (data_ph || resp_ph)), 32'd0);
`ifdef HP0_WR_DMA_STATS_EN
            chk("burst_cnt", burst_cnt, 32'(mdl_bcnt));
            chk("err_cnt", 32'(err_cnt), 32'(mdl_ecnt));
`endif
            if (m_wvalid) begin
                if (mdl_q.size() == 0) chk("w_underflow", 32'd1, 32'd0);
                else                   chk("wdata", m_wdata, mdl_q[0]);
            end
            if (m_awvalid && m_awready) begin
                chk("awaddr", m_awaddr, (cfg_base & 32'hFFFF_FFC0) + mdl_ptr);
                chk("awlen", 32'(m_awlen), 32'd15);
                chk("aw_const", 32'({m_awburst, m_awsize, m_awcache, m_awlock, m_awprot,
                                     m_awqos, m_awid, m_wid, m_wstrb}),
                    32'({2'b01, 3'b010, 4'b0011, 2'b00, 3'b000, 4'h0, 6'd0, 6'd0, 4'hF}));
                chk("aw_full_burst", 32'(mdl_q.size() >= 16), 32'd1);
                aw_log.push_back(m_awaddr);
                data_ph = 1; beat_idx = 0; n_aw++;
            end
            if (m_wvalid && m_wready) begin
                if (mdl_q.size() > 0) void'(mdl_q.pop_front());
                if (beat_idx == 15) begin
                    data_ph = 0; resp_ph = 1;
                end
                beat_idx++;
            end
            if (m_bvalid && m_bready) begin
                mdl_ptr = (mdl_ptr + 32'd64) % ring_bytes();
                if (m_bresp != 2'b00) begin
                    mdl_err = 1;
                    if (mdl_ecnt < 65535) mdl_ecnt++;
                end
                mdl_bcnt++;
                resp_ph = 0; n_b++;
            end
            if (s_valid && cfg_en && mdl_q.size() == DEPTH) mdl_ovf = 1;
            if (cfg_en && !en_prev) begin
                mdl_q.delete();
                mdl_ptr = 0; mdl_err = 0; mdl_ovf = 0; mdl_bcnt = 0; mdl_ecnt = 0;
            end
            if (s_valid && exp_rdy) mdl_q.push_back(s_data);
            en_prev = cfg_en;
        end
    end

    // AXI slave with optional back-pressure and injected error responses
    initial begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0;
            end else begin
                m_awready = aw_hold ? 1'b0 : (slave_rand ? 1'($urandom_range(0, 1)) : 1'b1);
                if (stall_left > 0 && data_ph && m_wvalid && beat_idx == stall_beat) begin
                    m_wready = 0;
                    stall_left--;
                end else begin
                    m_wready = slave_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (!resp_ph) begin
                    m_bvalid = 0;
                end else if (!m_bvalid && (!slave_rand || $urandom_range(0, 1) == 1)) begin
                    m_bvalid = 1;
                    if (n_b == err_at)                                  m_bresp = 2'b10;
                    else if (rand_err && $urandom_range(0, 5) == 0)     m_bresp = 2'($urandom_range(1, 3));
                    else                                                m_bresp = 2'b00;
                end
            end
        end
    end

    task automatic push_words(input int n, input bit gaps);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 0;
                @(posedge clk); #1;
            end
            s_valid = 1;
            s_data  = $urandom;
            t = 0;
            @(negedge clk);
            while (!s_ready && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) chk("push_timeout", 32'd1, 32'd0);
            @(posedge clk); #1;
        end
        s_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(!data_ph && !resp_ph && !m_awvalid && mdl_q.size() < 16) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic restart(input logic [31:0] base, input logic [19:0] nb);
        cfg_en = 0;
        @(posedge clk); #1;
        cfg_base = base; cfg_bursts = nb; cfg_en = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_b0, n_aw0, lat, t;
        bit found;
        rst = 1; cfg_en = 0; cfg_base = 0; cfg_bursts = 0; s_valid = 0; s_data = 0;
        aw_hold = 0; slave_rand = 0; rand_err = 0; stall_left = 0; stall_beat = 7; err_at = -1;
        n_aw = 0; n_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_awvalid", 32'(m_awvalid), 32'd0);
        chk("rst_wvalid", 32'(m_wvalid), 32'd0);
        chk("rst_wlast", 32'(m_wlast), 32'd0);
        chk("rst_bready", 32'(m_bready), 32'd0);
        chk("rst_wr_ptr", wr_ptr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // Four-burst ring, always-ready slave
        restart(32'h1000_0000, 20'd4);
        n_b0 = n_b; aw_log.delete();
        push_words(64, 1'b0);
        wait_idle();
        chk("t1_bursts", 32'(n_b - n_b0), 32'd4);
        chk("t1_aw_count", 32'(aw_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < aw_log.size(); i++)
            chk("t1_addr", aw_log[i], 32'h1000_0000 + 32'(i * 64));
        chk("t1_wr_ptr", wr_ptr, 32'd0);

        // No partial bursts; 16th word triggers AW quickly
        restart(32'h2000_0057, 20'd3);
        push_words(15, 1'b0);
        n_aw0 = n_aw;
        repeat (20) @(negedge clk);
        chk("t2_no_partial", 32'(n_aw - n_aw0), 32'd0);
        chk("t2_awvalid_low", 32'(m_awvalid), 32'd0);
        @(posedge clk); #1;
        push_words(1, 1'b0);
        found = 0; lat = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (m_awvalid && !found) begin found = 1; lat = k; end
        end
        chk("t2_aw_latency", 32'(found && lat <= 2), 32'd1);
        @(posedge clk); #1;
        wait_idle();

        // W back-pressure at beat 7
        restart(32'h3000_0000, 20'd2);
        stall_beat = 7; stall_left = 3;
        n_b0 = n_b;
        push_words(16, 1'b0);
        wait_idle();
        chk("t3_stall_used", 32'(stall_left), 32'd0);
        chk("t3_bursts", 32'(n_b - n_b0), 32'd1);

        // SLVERR on second burst
        restart(32'h4000_0000, 20'd8);
        err_at = n_b + 1;
        push_words(48, 1'b0);
        wait_idle();
        err_at = -1;
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_wr_ptr", wr_ptr, 32'd192);
`ifdef HP0_WR_DMA_STATS_EN
        chk("t4_err_cnt", 32'(err_cnt), 32'd1);
`endif

        // Overflow with AW stalled, then enable dropped mid-burst
        restart(32'h5000_0000, 20'd4);
        aw_hold = 1;
        push_words(64, 1'b0);
        s_valid = 1; s_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t5_s_ready_full", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        s_valid = 0;
        @(negedge clk);
        chk("t5_ovf", 32'(ovf), 32'd1);
        @(posedge clk); #1;
        aw_hold = 0;
        n_b0 = n_b;
        t = 0;
        @(negedge clk);
        while (!(data_ph && beat_idx >= 3) && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) chk("t5_data_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        cfg_en = 0;
        t = 0;
        @(negedge clk);
        while ((data_ph || resp_ph) && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) chk("t5_done_timeout", 32'd1, 32'd0);
        chk("t5_one_burst", 32'(n_b - n_b0), 32'd1);
        n_aw0 = n_aw;
        repeat (20) @(negedge clk);
        chk("t5_no_new_aw", 32'(n_aw - n_aw0), 32'd0);
        chk("t5_awvalid_low", 32'(m_awvalid), 32'd0);
        @(posedge clk); #1;

        // Randomized rings, back-pressure and responses
        slave_rand = 1; rand_err = 1;
        for (int it = 0; it < 8; it++) begin
            restart($urandom, 20'($urandom_range(0, 5)));
            push_words($urandom_range(10, 90), 1'b1);
            wait_idle();
        end
        slave_rand = 0; rand_err = 0;
        cfg_en = 0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
